riv_timer: RTL and testbench
============================

RIV_TIMER -- requirements
Module: riv_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, count/reload width (2..32).
REQ-002 SHALL have parameter PRE_W, default 4, prescaler field width (1..8).
REQ-003 SHALL have parameter EXP_W, default 8, expiry-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port value  input  WIDTH  reload value, sampled on load.
REQ-007 SHALL have port prescale  input  PRE_W  divide ratio minus one, sampled on load.
REQ-008 SHALL have port periodic  input  1  mode, sampled on load: 1 = auto-reload, 0 = one-shot.
REQ-009 SHALL have port load  input  1  capture value/prescale/periodic and start.
REQ-010 SHALL have port abort  input  1  stop and return to IDLE.
REQ-011 SHALL have port enable  input  1  count-qualifying strobe.
REQ-012 SHALL have port count  output  WIDTH  current count.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port expire  output  1  one-cycle pulse per expiry.
REQ-016 SHALL have port exp_cnt  output  EXP_W  saturating expiry count since last load.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-018 Priority SHALL be abort > load > tick, evaluated per cycle.
REQ-019 abort SHALL set state IDLE, count 0, exp_cnt 0, prescaler 0, expire 0 next cycle.
REQ-020 load with value==0 SHALL go to DONE, count 0, exp_cnt 0, no expire pulse, any mode.
REQ-021 load with value!=0 SHALL go to RUN, count=value, exp_cnt 0, prescaler 0, from any state.
REQ-022 tick SHALL be asserted when state==RUN, enable==1 and prescaler==captured prescale; prescaler increments on each enabled RUN cycle, clears on tick.
REQ-023 On tick with count>1, count SHALL decrement by 1.
REQ-024 On tick with count==1, one-shot: count->0, state->DONE; periodic: count->captured reload, state stays RUN.
REQ-025 expire SHALL be registered, high exactly the cycle after the count==1 tick edge, else 0.
REQ-026 exp_cnt SHALL increment on each expiry, saturating at 2^EXP_W-1, never wrapping.
REQ-027 In IDLE and DONE, enable SHALL have no effect; count never wraps below 0.
REQ-028 prescale==0 SHALL give one tick per enabled cycle; value V, prescale P SHALL expire after V*(P+1) enabled RUN cycles.
REQ-029 load during RUN SHALL restart cleanly; a coincident tick SHALL be discarded and no expire issued.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, count 0, busy 0, done 0, expire 0, exp_cnt 0, prescaler 0, captured reload/prescale/mode 0.
REQ-031 Reset assertion mid-RUN SHALL abandon the run with no expire pulse; release SHALL leave block in IDLE awaiting load.

Structure
REQ-032 State enumeration SHALL live in shared package riv_counter_pkg alongside width-limit constants.
REQ-033 Prescaler SHALL be one sub-module riv_prescaler (PRE_W, clear, enable, ratio -> tick).
REQ-034 All outputs SHALL be registered; no combinational input-to-output paths.

Verification
REQ-035 WIDTH=16, prescale=0, one-shot, load value=5, enable held -> count 5,4,3,2,1,0; expire once cycle after 1->0 edge; done=1, exp_cnt=1.
REQ-036 periodic, value=3, prescale=2, enable held 27 cycles -> 3 expire pulses 9 cycles apart; count reloads 1->3; exp_cnt=3; busy stays 1.
REQ-037 load value=0 -> done=1 next cycle, expire never pulses, enable ignored, count stays 0.
REQ-038 EXP_W=2, periodic value=1, prescale=0, 6 enabled cycles -> exp_cnt 1,2,3,3,3,3.
REQ-039 abort and load same cycle in RUN -> IDLE, count 0; load with count==1 tick -> count=new value, no expire.
REQ-040 rst asserted mid-RUN asynchronously (between edges) -> outputs 0 immediately; after release enable has no effect until load.

Source files
------------

// File: rtl/riv_counter_pkg.sv
// rtl/riv_counter_pkg.sv - shared state encoding and parameter limits for the timer
package riv_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int PRE_W_MIN = 1;
  localparam int PRE_W_MAX = 8;

endpackage

// File: rtl/riv_prescaler.sv
// rtl/riv_prescaler.sv - enable-qualified divider; tick fires when the count reaches ratio
module riv_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] ratio,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == ratio);
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/riv_timer.sv
// rtl/riv_timer.sv - one-shot / auto-reload down-counter with prescaler and expiry count
module riv_timer
  import riv_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PRE_W = 4,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic [PRE_W-1:0] prescale,
  input  logic             periodic,
  input  logic             load,
  input  logic             abort,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire,
  output logic [EXP_W-1:0] exp_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             mode_q, mode_d;
  logic             expire_q, expire_d;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic             tick;

  // A tick in the same cycle as load/abort is discarded by the priority below.
  riv_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (abort | load),
    .enable ((state_q == ST_RUN) && enable),
    .ratio  (pre_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      pre_q     <= '0;
      mode_q    <= 1'b0;
      expire_q  <= 1'b0;
      exp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      pre_q     <= pre_d;
      mode_q    <= mode_d;
      expire_q  <= expire_d;
      exp_cnt_q <= exp_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    pre_d     = pre_q;
    mode_d    = mode_q;
    expire_d  = 1'b0;
    exp_cnt_d = exp_cnt_q;
    if (abort) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      exp_cnt_d = '0;
    end else if (load) begin
      reload_d  = value;
      pre_d     = prescale;
      mode_d    = periodic;
      exp_cnt_d = '0;
      count_d   = value;
      state_d   = (value == '0) ? ST_DONE : ST_RUN;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - 1'b1;
      end else begin
        expire_d = 1'b1;
        if (exp_cnt_q != '1) begin
          exp_cnt_d = exp_cnt_q + 1'b1;
        end
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    count   = count_q;
    expire  = expire_q;
    exp_cnt = exp_cnt_q;
  end

endmodule

// File: tb/tb_riv_timer.sv
// tb/tb_riv_timer.sv - scoreboard bench for riv_timer
module tb_riv_timer;

  localparam int SIG_COUNT  = 0;
  localparam int SIG_BUSY   = 1;
  localparam int SIG_DONE   = 2;
  localparam int SIG_EXPIRE = 3;
  localparam int SIG_EXPCNT = 4;
  localparam int SIG_EXPC2  = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  prescale = '0;
  logic        periodic = 1'b0;
  logic        load = 1'b0;
  logic        abort = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] count, count2;
  logic        busy, done, expire, busy2, done2, expire2;
  logic [7:0]  exp_cnt;
  logic [1:0]  exp_cnt2;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riv_timer #(.WIDTH(16), .PRE_W(4), .EXP_W(8)) u_dut (
    .clk(clk), .rst(rst), .value(value), .prescale(prescale), .periodic(periodic),
    .load(load), .abort(abort), .enable(enable), .count(count), .busy(busy),
    .done(done), .expire(expire), .exp_cnt(exp_cnt)
  );

  riv_timer #(.WIDTH(16), .PRE_W(4), .EXP_W(2)) u_dut_e2 (
    .clk(clk), .rst(rst), .value(value), .prescale(prescale), .periodic(periodic),
    .load(load), .abort(abort), .enable(enable), .count(count2), .busy(busy2),
    .done(done2), .expire(expire2), .exp_cnt(exp_cnt2)
  );

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      SIG_COUNT:  return 32'(count);
      SIG_BUSY:   return 32'(busy);
      SIG_DONE:   return 32'(done);
      SIG_EXPIRE: return 32'(expire);
      SIG_EXPCNT: return 32'(exp_cnt);
      default:    return 32'(exp_cnt2);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_all(input string tag, input int c, input int b, input int d,
                          input int x, input int ec);
    push({tag, ".count"}, SIG_COUNT, 32'(c));
    push({tag, ".busy"}, SIG_BUSY, 32'(b));
    push({tag, ".done"}, SIG_DONE, 32'(d));
    push({tag, ".expire"}, SIG_EXPIRE, 32'(x));
    push({tag, ".exp_cnt"}, SIG_EXPCNT, 32'(ec));
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs(e.sig), e.val);
    end
  endtask

  task automatic drive(input logic ld, input logic ab, input logic en,
                       input logic [15:0] v, input logic [3:0] p, input logic per);
    load = ld;
    abort = ab;
    enable = en;
    value = v;
    prescale = p;
    periodic = per;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push_all("reset", 0, 0, 0, 0, 0);
    push("reset.exp_cnt2", SIG_EXPC2, 0);
    drain();
    rst = 1'b0;

    // one-shot 5 -> 0 at one tick per cycle
    drive(1, 0, 1, 16'd5, 4'd0, 0);
    push_all("os_load", 5, 1, 0, 0, 0);
    step();
    drive(0, 0, 1, 16'd0, 4'd0, 0);
    for (int c = 4; c >= 1; c--) begin
      push_all($sformatf("os_cnt%0d", c), c, 1, 0, 0, 0);
      step();
    end
    push_all("os_expire", 0, 0, 1, 1, 1);
    step();
    push_all("os_after", 0, 0, 1, 0, 1);
    step();

    // periodic 3 with prescale 2: expiry every 9 enabled cycles
    drive(1, 0, 1, 16'd3, 4'd2, 1);
    push_all("per_load", 3, 1, 0, 0, 0);
    step();
    drive(0, 0, 1, 16'd0, 4'd0, 0);
    for (int i = 1; i <= 27; i++) begin
      push($sformatf("per_c%0d", i), SIG_COUNT, 32'(3 - ((i / 3) % 3)));
      push($sformatf("per_x%0d", i), SIG_EXPIRE, 32'((i % 9) == 0));
      push($sformatf("per_b%0d", i), SIG_BUSY, 1);
      step();
    end
    push("per_expcnt", SIG_EXPCNT, 3);
    drain();

    // zero load goes straight to DONE in either mode
    drive(1, 0, 1, 16'd0, 4'd3, 1);
    push_all("zero_load", 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 1, 16'd0, 4'd0, 0);
    for (int i = 0; i < 4; i++) begin
      push_all($sformatf("zero_en%0d", i), 0, 0, 1, 0, 0);
      step();
    end

    // 2-bit expiry counter saturates at 3
    drive(1, 0, 0, 16'd1, 4'd0, 1);
    push("sat_load", SIG_EXPC2, 0);
    step();
    drive(0, 0, 1, 16'd0, 4'd0, 0);
    for (int i = 1; i <= 6; i++) begin
      push($sformatf("sat_e%0d", i), SIG_EXPC2, 32'((i > 3) ? 3 : i));
      push($sformatf("sat_x%0d", i), SIG_EXPIRE, 1);
      push($sformatf("sat_c%0d", i), SIG_COUNT, 1);
      step();
    end

    // abort beats load; load beats a coincident final tick
    drive(1, 0, 1, 16'd4, 4'd0, 0);
    push_all("ab_load", 4, 1, 0, 0, 0);
    step();
    drive(1, 1, 1, 16'd7, 4'd0, 0);
    push_all("ab_both", 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 16'd2, 4'd0, 0);
    push_all("rl_load", 2, 1, 0, 0, 0);
    step();
    drive(0, 0, 1, 16'd0, 4'd0, 0);
    push_all("rl_tick", 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 1, 16'd6, 4'd0, 0);
    push_all("rl_coinc", 6, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 16'd0, 4'd0, 0);
    push_all("rl_hold", 6, 1, 0, 0, 0);
    step();

    // asynchronous reset between edges mid-run
    drive(1, 0, 1, 16'd5, 4'd0, 0);
    push_all("ar_load", 5, 1, 0, 0, 0);
    step();
    drive(0, 0, 1, 16'd0, 4'd0, 0);
    push_all("ar_run", 4, 1, 0, 0, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    push_all("ar_async", 0, 0, 0, 0, 0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_all($sformatf("ar_idle%0d", i), 0, 0, 0, 0, 0);
      step();
    end
    drive(1, 0, 1, 16'd2, 4'd0, 0);
    push_all("ar_reload", 2, 1, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
